// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic result collector.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } collector_state_e;

  // Watchdog budget per collection slot; one slot per skew step plus one.
  localparam int TIMEOUT_CYCLES_PER_SLOT = 4;

  // Pointer width for a buffer of the given depth, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Idle-cycle limit in COLLECT before the watchdog flags a stalled job.
  function automatic int timeout_limit(input int matrix_size);
    return (2 * matrix_size + 1) * TIMEOUT_CYCLES_PER_SLOT;
  endfunction

endpackage

// File: rtl/systolic_result_collector_if.sv
// Input partial-sum stream and output result-row stream of the collector.
// slave: the collector itself; master: the array side plus writeback side.
interface systolic_result_collector_if #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
);
  logic [MATRIX_SIZE*DATA_SIZE-1:0]   in_psum;
  logic [MATRIX_SIZE-1:0]             in_valid;
  logic [MATRIX_SIZE*DATA_SIZE-1:0]   out_row;
  logic [$clog2(MATRIX_SIZE):0]       out_row_idx;
  logic                               out_valid;
  logic                               out_ready;

  modport slave (
    input  in_psum, in_valid, out_ready,
    output out_row, out_row_idx, out_valid
  );

  modport master (
    output in_psum, in_valid, out_ready,
    input  out_row, out_row_idx, out_valid
  );
endinterface

// File: rtl/collector_column_fifo.sv
// Per-column deskew buffer: small FIFO with wrapping binary pointers and an
// occupancy count. The caller guarantees push only when not full or popping.
module collector_column_fifo
  import systolic_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 full,
  output logic                 empty
);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage write; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer for a new job.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Deskews per-column partial sums leaving the array into aligned result rows,
// streams them to writeback and flags completion after MATRIX_SIZE rows.
// Optional: SYSTOLIC_COLLECTOR_TIMEOUT_EN adds a sticky `timeout` watchdog.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  systolic_result_collector_if.slave bus,
  output logic done,
  output logic overflow
`ifdef SYSTOLIC_COLLECTOR_TIMEOUT_EN
  , output logic timeout
`endif
);
  localparam int IDX_W = $clog2(MATRIX_SIZE) + 1;

  collector_state_e                 state;
  collector_state_e                 state_next;
  logic                             collecting;
  logic                             pop;
  logic                             accept;
  logic                             last_accept;
  logic [MATRIX_SIZE-1:0]           col_push;
  logic [MATRIX_SIZE-1:0]           col_drop;
  logic [MATRIX_SIZE-1:0]           col_full;
  logic [MATRIX_SIZE-1:0]           col_empty;
  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_head;
  logic [IDX_W-1:0]                 pop_count;
  logic [IDX_W-1:0]                 accept_count;

  // Inputs arriving with start belong to no job and are discarded.
  assign collecting  = (state == ST_COLLECT) && !start;
  // A row leaves only when every column has its element and the output slot frees.
  assign pop         = collecting && (col_empty == '0) &&
                       (pop_count != IDX_W'(MATRIX_SIZE)) &&
                       (!bus.out_valid || bus.out_ready);
  assign accept      = collecting && bus.out_valid && bus.out_ready;
  assign last_accept = accept && (accept_count == IDX_W'(MATRIX_SIZE - 1));

  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    assign col_push[j] = collecting && bus.in_valid[j] && (!col_full[j] || pop);
    assign col_drop[j] = collecting && bus.in_valid[j] && col_full[j] && !pop;

    collector_column_fifo #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (MATRIX_SIZE)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (start),
      .push  (col_push[j]),
      .pop   (pop),
      .din   (bus.in_psum[j*DATA_SIZE +: DATA_SIZE]),
      .dout  (col_head[j*DATA_SIZE +: DATA_SIZE]),
      .full  (col_full[j]),
      .empty (col_empty[j])
    );
  end

  // Job state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start always (re)opens a job; the final acceptance closes it.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_COLLECT;
    end else begin
      case (state)
        ST_IDLE:    state_next = ST_IDLE;
        ST_COLLECT: begin
          if (last_accept) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_COLLECT;
          end
        end
        ST_DONE:    state_next = ST_DONE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Output row register, row counters and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_row     <= '0;
      bus.out_row_idx <= '0;
      bus.out_valid   <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      pop_count       <= '0;
      accept_count    <= '0;
    end else if (start) begin
      bus.out_row_idx <= '0;
      bus.out_valid   <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      pop_count       <= '0;
      accept_count    <= '0;
    end else begin
      if (pop) begin
        bus.out_row     <= col_head;
        bus.out_row_idx <= pop_count;
        bus.out_valid   <= 1'b1;
        pop_count       <= pop_count + IDX_W'(1);
      end else if (accept) begin
        bus.out_valid   <= 1'b0;
      end
      if (accept) begin
        accept_count <= accept_count + IDX_W'(1);
      end
      if (last_accept) begin
        done <= 1'b1;
      end
      if (col_drop != '0) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef SYSTOLIC_COLLECTOR_TIMEOUT_EN
  localparam int TIMEOUT_LIMIT = timeout_limit(MATRIX_SIZE);
  localparam int WD_W          = $clog2(TIMEOUT_LIMIT) + 1;

  logic [WD_W-1:0] wd_count;

  // Watchdog: counts COLLECT cycles with no push and no acceptance.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      wd_count <= '0;
      timeout  <= 1'b0;
    end else if (state == ST_COLLECT) begin
      if ((col_push != '0) || accept) begin
        wd_count <= '0;
      end else if (wd_count != WD_W'(TIMEOUT_LIMIT)) begin
        wd_count <= wd_count + WD_W'(1);
        if (wd_count == WD_W'(TIMEOUT_LIMIT - 1)) begin
          timeout <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_result_collector.sv
// Self-checking bench for systolic_result_collector (N=2, 32-bit elements).
// Per-cycle vector table for status outputs plus a scoreboard for row data.
module tb_systolic_result_collector;
  localparam int N = 2;
  localparam int D = 32;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;
  logic overflow;
`ifdef SYSTOLIC_COLLECTOR_TIMEOUT_EN
  logic timeout;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  systolic_result_collector_if #(.MATRIX_SIZE(N), .DATA_SIZE(D)) bus ();

  systolic_result_collector #(.MATRIX_SIZE(N), .DATA_SIZE(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .done     (done),
    .overflow (overflow)
`ifdef SYSTOLIC_COLLECTOR_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  typedef struct {
    logic        rst, st;
    logic [1:0]  vm;
    logic [31:0] p0, p1;
    logic        rdy;
    logic        ev;
    logic [1:0]  ei;
    logic        ed, eo;
    logic        sb;
    logic [31:0] s0, s1;
    logic [1:0]  si;
  } vec_t;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r0;
    logic [1:0]  idx;
  } row_t;

  vec_t vecs[$];
  row_t exp_q[$];

  logic        hold_pending = 1'b0;
  logic [65:0] hold_val;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // inputs: rst st vmask p0 p1 ready | expected after edge: valid idx done ovf | scoreboard row
  function automatic void add(input int rst, input int st, input int vm, input int p0, input int p1,
                              input int rdy, input int ev, input int ei, input int ed, input int eo,
                              input int sb = 0, input int s0 = 0, input int s1 = 0, input int si = 0);
    vec_t t;
    t.rst = 1'(rst); t.st = 1'(st); t.vm = 2'(vm); t.p0 = p0; t.p1 = p1; t.rdy = 1'(rdy);
    t.ev = 1'(ev); t.ei = 2'(ei); t.ed = 1'(ed); t.eo = 1'(eo);
    t.sb = 1'(sb); t.s0 = s0; t.s1 = s1; t.si = 2'(si);
    vecs.push_back(t);
  endfunction

  function automatic void idle(input int n, input int rdy, input int ev, input int ei,
                               input int ed, input int eo);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, 0, rdy, ev, ei, ed, eo);
  endfunction

  // Scoreboard and hold monitor, sampled mid-cycle ahead of the next active edge.
  always @(negedge clk) begin
    if (!reset && !start && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got row %0h idx %0d, expected no row", bus.out_row, bus.out_row_idx);
      end else begin
        check("sb_row", 72'({bus.out_row, bus.out_row_idx}), 72'({exp_q[0].r1, exp_q[0].r0, exp_q[0].idx}));
        void'(exp_q.pop_front());
      end
    end
    if (hold_pending) begin
      check("hold", 72'({bus.out_valid, bus.out_row, bus.out_row_idx}), 72'({1'b1, hold_val}));
    end
    hold_pending = !reset && !start && bus.out_valid && !bus.out_ready;
    hold_val     = {bus.out_row, bus.out_row_idx};
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    bus.in_valid = '0; bus.in_psum = '0; bus.out_ready = 1'b1;

    // Reset
    add(1,0,0,0,0,1, 0,0,0,0); add(1,0,0,0,0,1, 0,0,0,0);
    idle(1,1, 0,0,0,0);
    // Skewed collect, ready always high
    add(0,1,0,0,0,1, 0,0,0,0);
    add(0,0,1,10,0,1, 0,0,0,0);
    idle(3,1, 0,0,0,0);
    add(0,0,3,20,11,1, 0,0,0,0, 1,10,11,0);
    idle(1,1, 1,0,0,0);
    idle(2,1, 0,0,0,0);
    add(0,0,2,0,21,1, 0,0,0,0, 1,20,21,1);
    idle(1,1, 1,1,0,0);
    idle(1,1, 0,1,1,0);
    add(0,0,3,99,98,1, 0,1,1,0);
    // Backpressure
    add(0,1,0,0,0,1, 0,0,0,0);
    add(0,0,1,10,0,1, 0,0,0,0);
    idle(3,1, 0,0,0,0);
    add(0,0,3,20,11,1, 0,0,0,0, 1,10,11,0);
    idle(3,0, 1,0,0,0);
    add(0,0,2,0,21,0, 1,0,0,0, 1,20,21,1);
    idle(4,0, 1,0,0,0);
    idle(1,1, 1,1,0,0);
    idle(1,1, 0,1,1,0);
    // Overflow on column 0
    add(0,1,0,0,0,1, 0,0,0,0);
    add(0,0,1,1,0,1, 0,0,0,0);
    add(0,0,1,2,0,1, 0,0,0,0);
    add(0,0,1,3,0,1, 0,0,0,1);
    add(0,0,2,0,7,1, 0,0,0,1, 1,1,7,0);
    add(0,0,2,0,8,1, 1,0,0,1, 1,2,8,1);
    idle(1,1, 1,1,0,1);
    idle(1,1, 0,1,1,1);
    // Push on a full column while popping
    add(0,1,0,0,0,1, 0,0,0,0);
    add(0,0,1,1,0,1, 0,0,0,0);
    add(0,0,1,2,0,1, 0,0,0,0);
    add(0,0,2,0,5,1, 0,0,0,0, 1,1,5,0);
    add(0,0,1,3,0,1, 1,0,0,0);
    add(0,0,2,0,6,1, 0,0,0,0, 1,2,6,1);
    idle(1,1, 1,1,0,0);
    idle(1,1, 0,1,1,0);
    // Restart with a row pending and overflow set; inputs with start dropped
    add(0,1,0,0,0,1, 0,0,0,0);
    add(0,0,3,100,101,0, 0,0,0,0);
    add(0,0,0,0,0,0, 1,0,0,0);
    add(0,0,1,9,0,0, 1,0,0,0);
    add(0,0,1,9,0,0, 1,0,0,0);
    add(0,0,1,9,0,0, 1,0,0,1);
    add(0,1,3,50,51,0, 0,0,0,0);
    add(0,0,3,30,31,1, 0,0,0,0, 1,30,31,0);
    add(0,0,3,40,41,1, 1,0,0,0, 1,40,41,1);
    idle(1,1, 1,1,0,0);
    idle(1,1, 0,1,1,0);
    // Reset in mid-COLLECT, then a fresh job
    add(0,1,0,0,0,1, 0,0,0,0);
    add(0,0,3,5,6,1, 0,0,0,0);
    add(0,0,0,0,0,0, 1,0,0,0);
    add(0,0,1,7,0,0, 1,0,0,0);
    add(0,0,1,7,0,0, 1,0,0,0);
    add(0,0,1,7,0,0, 1,0,0,1);
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,0,3,1,2,1, 0,0,0,0);
    add(0,1,0,0,0,1, 0,0,0,0);
    add(0,0,3,3,4,1, 0,0,0,0, 1,3,4,0);
    idle(1,1, 1,0,0,0);
    add(0,0,3,5,6,1, 0,0,0,0, 1,5,6,1);
    idle(1,1, 1,1,0,0);
    idle(1,1, 0,1,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset         = vecs[i].rst;
      start         = vecs[i].st;
      bus.in_valid  = vecs[i].vm;
      bus.in_psum   = {vecs[i].p1, vecs[i].p0};
      bus.out_ready = vecs[i].rdy;
      if (vecs[i].sb) exp_q.push_back({vecs[i].s1, vecs[i].s0, vecs[i].si});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 72'({bus.out_valid, bus.out_row_idx, done, overflow}),
            72'({vecs[i].ev, vecs[i].ei, vecs[i].ed, vecs[i].eo}));
      if (vecs[i].rst) check($sformatf("rst_row%0d", i), 72'(bus.out_row), 72'd0);
    end
    reset = 1'b0; start = 1'b0; bus.in_valid = '0; bus.out_ready = 1'b1;

`ifdef SYSTOLIC_COLLECTOR_TIMEOUT_EN
    // Watchdog: no inputs after start
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("to_start", 72'(timeout), 72'd0);
    repeat (19) @(posedge clk);
    #1;
    check("to_early", 72'(timeout), 72'd0);
    @(posedge clk); #1;
    check("to_hit", 72'(timeout), 72'd1);
    @(posedge clk); #1;
    check("to_sticky", 72'(timeout), 72'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("to_clear", 72'(timeout), 72'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 72'(exp_q.size()), 72'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
